// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - command/response byte codes and FSM encoding shared by the UART register command master
package uart_cmd_pkg;

  localparam int ADDR_W = 16;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_NAK = 8'h4E;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_DATA    = 3'd3,
    ST_WRITE   = 3'd4,
    ST_READ    = 3'd5,
    ST_RESP    = 3'd6,
    ST_NAK     = 3'd7
  } state_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WR) || (b == CMD_RD);
  endfunction

endpackage

// File: rtl/uart_resp_shifter.sv
// rtl/uart_resp_shifter.sv - loadable NB-byte response buffer, presented MSB first on a valid/ready byte stream
module uart_resp_shifter #(
  parameter int NB = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_load,
  input  logic [NB*8-1:0] i_load_data,
  input  logic [7:0]      i_load_cnt,
  output logic [7:0]      o_tx_data,
  output logic            o_tx_valid,
  input  logic            i_tx_ready,
  output logic            o_done
);

  logic [NB*8-1:0] r_buf;
  logic [7:0]      r_cnt;
  logic            w_accept;

  assign o_tx_valid = (r_cnt != 8'd0);
  assign o_tx_data  = r_buf[NB*8-1 -: 8];
  assign w_accept   = o_tx_valid && i_tx_ready;
  assign o_done     = w_accept && (r_cnt == 8'd1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_buf <= i_load_data;
      r_cnt <= i_load_cnt;
    end else if (w_accept) begin
      r_buf <= r_buf << 8;
      r_cnt <= r_cnt - 8'd1;
    end
  end

endmodule

// File: rtl/uart_reg_cmd_master.sv
// rtl/uart_reg_cmd_master.sv - parses UART bytes into register read/write commands and returns data or ACK/NAK
// Optional read timeout compiled in with UART_REG_RD_TIMEOUT_EN.
module uart_reg_cmd_master
  import uart_cmd_pkg::*;
#(
  parameter int BYTE       = 4,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  input  logic                i_rx_error,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  output logic [ADDR_W-1:0]   o_addr,
  output logic [BYTE*4-1:0]   o_reg_wr_data,
  output logic                o_reg_wr_valid,
  output logic                o_rw,
  output logic                o_rd_en,
  input  logic [BYTE*4-1:0]   i_reg_rd_data,
  input  logic                i_reg_rd_valid,
  output logic                o_busy,
  output logic                o_overrun
);

  localparam int NB = BYTE / 2;
  localparam int RW = BYTE * 4;

  if (BYTE < 2 || (BYTE % 2) != 0 || RD_TIMEOUT < 1 || RD_TIMEOUT > 255) begin : g_param_check
    $error("uart_reg_cmd_master: BYTE must be even >= 2, RD_TIMEOUT in 1..255");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_is_read;
  logic              r_rw;
  logic [7:0]        r_dcnt;
  logic [ADDR_W-1:0] r_addr;
  logic [RW-1:0]     r_wr_data;
  logic              w_rx_ok;
  logic              w_timeout;
  logic              w_load;
  logic [RW-1:0]     w_load_data;
  logic [7:0]        w_load_cnt;
  logic              w_done;

  // An error strobe discards any byte arriving with it.
  assign w_rx_ok = i_rx_valid && !i_rx_error;

`ifdef UART_REG_RD_TIMEOUT_EN
  logic [7:0] r_to_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || (r_state != ST_READ)) r_to_cnt <= '0;
    else                                 r_to_cnt <= r_to_cnt + 8'd1;
  end

  assign w_timeout = (r_state == ST_READ) && (r_to_cnt == 8'(RD_TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_rx_valid) w_state_nxt = is_cmd(i_rx_data) ? ST_ADDR_HI : ST_NAK;
      end
      ST_ADDR_HI: begin
        if (i_rx_error)      w_state_nxt = ST_NAK;
        else if (i_rx_valid) w_state_nxt = ST_ADDR_LO;
      end
      ST_ADDR_LO: begin
        if (i_rx_error)      w_state_nxt = ST_NAK;
        else if (i_rx_valid) w_state_nxt = r_is_read ? ST_READ : ST_DATA;
      end
      ST_DATA: begin
        if (i_rx_error)                         w_state_nxt = ST_NAK;
        else if (i_rx_valid && r_dcnt == 8'd0)  w_state_nxt = ST_WRITE;
      end
      ST_WRITE: w_state_nxt = ST_RESP;
      ST_READ: begin
        if (i_reg_rd_valid) w_state_nxt = ST_RESP;
        else if (w_timeout) w_state_nxt = ST_NAK;
      end
      ST_RESP: if (w_done) w_state_nxt = ST_IDLE;
      ST_NAK:  if (w_done) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_reg_wr_valid = 1'b0;
    o_rd_en        = 1'b0;
    o_busy         = (r_state != ST_IDLE);
    o_overrun      = 1'b0;
    w_load         = 1'b0;
    w_load_data    = '0;
    w_load_cnt     = 8'd0;
    case (r_state)
      ST_WRITE: begin
        o_reg_wr_valid          = 1'b1;
        o_overrun               = i_rx_valid;
        w_load                  = 1'b1;
        w_load_data[RW-1 -: 8]  = RSP_ACK;
        w_load_cnt              = 8'd1;
      end
      ST_READ: begin
        o_rd_en   = 1'b1;
        o_overrun = i_rx_valid;
        if (i_reg_rd_valid) begin
          w_load      = 1'b1;
          w_load_data = i_reg_rd_data;
          w_load_cnt  = 8'(NB);
        end
      end
      ST_RESP, ST_NAK: o_overrun = i_rx_valid;
      default: ;
    endcase
    if (w_state_nxt == ST_NAK && r_state != ST_NAK) begin
      w_load                 = 1'b1;
      w_load_data            = '0;
      w_load_data[RW-1 -: 8] = RSP_NAK;
      w_load_cnt             = 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr    <= '0;
      r_wr_data <= '0;
      r_is_read <= 1'b0;
      r_rw      <= 1'b0;
      r_dcnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_rx_valid && is_cmd(i_rx_data)) r_is_read <= (i_rx_data == CMD_RD);
        ST_ADDR_HI, ST_ADDR_LO: if (w_rx_ok) r_addr <= (r_addr << 8) | ADDR_W'(i_rx_data);
        ST_DATA: begin
          if (w_rx_ok) begin
            r_wr_data <= (r_wr_data << 8) | RW'(i_rx_data);
            r_dcnt    <= r_dcnt - 8'd1;
          end
        end
        default: ;
      endcase
      if (r_state == ST_ADDR_LO && w_state_nxt == ST_DATA) r_dcnt <= 8'(NB - 1);
      // rw stays high through the read response and clears once the frame is finished
      if (w_state_nxt == ST_READ)                                r_rw <= 1'b1;
      else if (w_state_nxt == ST_IDLE || w_state_nxt == ST_NAK)  r_rw <= 1'b0;
    end
  end

  assign o_addr        = r_addr;
  assign o_reg_wr_data = r_wr_data;
  assign o_rw          = r_rw;

  uart_resp_shifter #(.NB(NB)) u_resp (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_load),
    .i_load_data (w_load_data),
    .i_load_cnt  (w_load_cnt),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .i_tx_ready  (i_tx_ready),
    .o_done      (w_done)
  );

endmodule

// File: doc/uart_reg_cmd_master.md
# uart_reg_cmd_master

Command-side counterpart of the user register file in the UART loopback design. It parses a byte stream from the UART receiver into register write/read commands and drives the register file's `addr`/`reg_wr_data`/`reg_wr_valid`/`rw`/`rd_en` inputs. It captures `reg_rd_data` on `reg_rd_valid` and serialises the result, or an ACK/NAK status byte, back to the UART transmitter.

## Interface
- `BYTE`, 4: register width is `BYTE*4` bits. Data bytes per frame `NB = BYTE/2`. Must be even and ≥2.
- `RD_TIMEOUT`, 255: cycles to wait for `reg_rd_valid` when timeout is compiled in. Range 1–255.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe per received byte. There is no backpressure.
- `rx_error` in 1: framing/parity error strobe from the receiver.
- `tx_data` out 8: response byte.
- `tx_valid` out 1: response byte valid. Held with stable `tx_data` until accepted.
- `tx_ready` in 1: transmitter accepts the byte when `tx_valid & tx_ready`.
- `addr` out `` `ADDR_WIDTH ``: register address. 16 bits.
- `reg_wr_data` out `BYTE*4`: write data.
- `reg_wr_valid` out 1: one-cycle write strobe.
- `rw` out 1: 1 = read, 0 = write.
- `rd_en` out 1: read request level.
- `reg_rd_data` in `BYTE*4`: read data.
- `reg_rd_valid` in 1: read data valid strobe.
- `busy` out 1: high in every state except IDLE.
- `overrun` out 1: one-cycle pulse when a byte is dropped.

## Operation
- Frame format:
  - Write: `0x57`, then ADDR_HI, ADDR_LO, then NB data bytes MSB first.
  - Read: `0x52`, then ADDR_HI, ADDR_LO.
- Responses:
  - Write → `0x4B`.
  - Read → NB data bytes, MSB first.
  - Error → `0x4E`.
- States: IDLE, ADDR_HI, ADDR_LO, DATA, WRITE, READ, RESP, NAK.
- IDLE:
  - `rx_valid` with `0x57`/`0x52` latches the command and moves to ADDR_HI.
  - Any other byte moves to NAK.
- ADDR_HI/ADDR_LO shift bytes into `addr`. After ADDR_LO, a write moves to DATA and a read moves to READ.
- DATA: a down-counter `dcnt` (init NB-1) shifts bytes into `reg_wr_data`, MSB first. At `dcnt==0` with `rx_valid`, move to WRITE.
- WRITE:
  - Drive `reg_wr_valid=1` and `rw=0` for exactly one cycle.
  - Load `0x4B` into the response buffer with byte count 1, then go to RESP.
- READ:
  - Drive `rw=1` and `rd_en=1` until `reg_rd_valid`.
  - On `reg_rd_valid`, capture `reg_rd_data`, drop `rd_en`, load NB bytes, then go to RESP.
- RESP:
  - Present buffer bytes MSB first. Advance on each `tx_valid & tx_ready`.
  - After the last byte, `rw` returns to 0 and the block returns to IDLE.
- NAK: present `0x4E` until accepted, then return to IDLE.
- `rx_error` in any receive state (ADDR_HI, ADDR_LO, DATA) aborts the frame and goes to NAK. In IDLE it is ignored. In WRITE/READ/RESP/NAK it is ignored.
- `rx_valid` in WRITE/READ/RESP/NAK drops the byte and pulses `overrun`.
- Simultaneous `rx_valid` and `rx_error` in a receive state: the error wins and the byte is discarded.
- `rd_en` is always low for at least one cycle between two reads. This re-arms the register file's rising-edge detect.

## Timing
- Reset value of every output: 0. `addr`, `reg_wr_data`, `rw` and the buffers all reset to 0. State resets to IDLE.
- Reset mid-frame or mid-response abandons everything immediately. `tx_valid` drops the next cycle.
- Write: last data byte at cycle N → `reg_wr_valid` at N+1 → `tx_valid` with `0x4B` at N+2.
- Read: ADDR_LO at cycle N → `rd_en` high from N+1. With the register file, `reg_rd_valid` arrives at N+2. `rd_en` is low at N+3 and `tx_valid` carries the MSB byte at N+3.
- `tx_valid` never drops and `tx_data` never changes while `tx_ready` is low.
- Minimum gap between commands: none. A command byte accepted in the cycle the state returns to IDLE is processed.

## Configuration
- `UART_REG_RD_TIMEOUT_EN` defined:
  - An 8-bit counter runs in READ.
  - If `reg_rd_valid` has not arrived after `RD_TIMEOUT` cycles, drop `rd_en` and go to NAK.
  - `reg_rd_valid` in the same cycle as expiry wins.
- Undefined: READ waits indefinitely. No counter logic is generated.

## Structure
- Shared package `uart_cmd_pkg`:
  - Command codes `CMD_WR=0x57`, `CMD_RD=0x52`.
  - Response codes `RSP_ACK=0x4B`, `RSP_NAK=0x4E`.
  - State encoding.
- One sub-module, `uart_resp_shifter`: loadable NB-byte buffer with byte count and valid/ready output stage. It is used for both data and status responses.

## Test plan
- Write: bytes 57 00 03 AB CD → `reg_wr_valid` one cycle, `addr=0x0003`, `reg_wr_data=0xABCD`, `rw=0`. TX byte 4B.
- Read-back: the write above, then 52 00 03 → `rd_en` one pulse, TX bytes AB then CD. `tx_ready` is held low 5 cycles before each byte, and `tx_data` stays stable throughout.
- Bad command: byte 41 → TX 4E, `busy` low after acceptance. A following 52 00 00 returns 00 00.
- Error mid-frame: 57 00 `rx_error` → TX 4E. No `reg_wr_valid` occurs.
- Overrun: a byte sent while the read response is stalled → `overrun` pulses once and the response is unchanged.
- Timeout (macro defined, `RD_TIMEOUT=10`): `reg_rd_valid` tied low, then 52 00 01 → `rd_en` drops after 10 cycles and TX 4E. Without the macro, `rd_en` stays high for 1000 cycles. A reset asserted mid-read clears every output to 0 on the next edge.
